// File: rtl/dmem_wait_responder.sv
// rtl/dmem_wait_responder.sv - wait-state data-memory responder for the MIPS M stage
//
// Accepts one full-word load/store per request, holds the pipeline through a fixed
// number of wait cycles, then commits the access and presents the result for one
// DONE cycle.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous active-low reset
//   MemReqM    in   1   M-stage access request
//   MemWriteM  in   1   1 = store, 0 = load
//   ALUOutM    in   32  byte address
//   WriteDataM in   32  store data
//   ReadDataM  out  32  registered load data, valid in DONE
//   StallMem   out  1   hold pipeline while the access is in flight
//   AccessErr  out  1   misaligned / out-of-range flag, valid in DONE
module dmem_wait_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallMem,
  output logic        AccessErr
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_INIT = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_we;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic              w_accept;
  logic              w_commit;
  logic [31:0]       w_addr;
  logic [31:0]       w_data;
  logic              w_we;
  logic              w_err;
  logic [ADDR_W-1:0] w_index;

  assign w_accept = (r_state == S_IDLE) && MemReqM;
  // With zero wait states the access commits on the accept edge itself.
  assign w_commit = (w_accept && ZERO_WAIT) || ((r_state == S_WAIT) && (r_cnt == 4'd0));

  // In IDLE the only commit is the zero-wait one, which must use the live inputs
  // because the latches are being loaded on the same edge.
  assign w_addr  = (r_state == S_IDLE) ? ALUOutM    : r_addr;
  assign w_data  = (r_state == S_IDLE) ? WriteDataM : r_data;
  assign w_we    = (r_state == S_IDLE) ? MemWriteM  : r_we;
  assign w_err   = (w_addr[1:0] != 2'b00) || (w_addr[31:ADDR_W+2] != '0);
  assign w_index = w_addr[ADDR_W+1:2];

  assign StallMem = w_accept || (r_state == S_WAIT);

  // Memory is never cleared; the reset gate stops a write while reset is held.
  always_ff @(posedge clk) begin
    if (reset && w_commit && w_we && !w_err) begin
      r_mem[w_index] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= 32'd0;
      r_data    <= 32'd0;
      r_we      <= 1'b0;
      ReadDataM <= 32'd0;
      AccessErr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MemReqM) begin
            r_addr <= ALUOutM;
            r_data <= WriteDataM;
            r_we   <= MemWriteM;
            if (ZERO_WAIT) begin
              r_state <= S_DONE;
            end else begin
              r_cnt   <= WAIT_INIT;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // MemReqM here belongs to the instruction just served.
          AccessErr <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_commit) begin
        AccessErr <= w_err;
        if (w_err) begin
          ReadDataM <= 32'd0;
        end else if (!w_we) begin
          ReadDataM <= r_mem[w_index];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb/tb_dmem_wait_responder.sv - self-checking bench for dmem_wait_responder
module tb_dmem_wait_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req_a = 1'b0, we_a = 1'b0;
  logic [31:0] addr_a = '0, wd_a = '0, rd_a;
  logic        stall_a, err_a;

  logic        req_b = 1'b0, we_b = 1'b0;
  logic [31:0] addr_b = '0, wd_b = '0, rd_b;
  logic        stall_b, err_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_wait_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .reset(reset), .MemReqM(req_a), .MemWriteM(we_a), .ALUOutM(addr_a),
    .WriteDataM(wd_a), .ReadDataM(rd_a), .StallMem(stall_a), .AccessErr(err_a)
  );

  dmem_wait_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(reset), .MemReqM(req_b), .MemWriteM(we_b), .ALUOutM(addr_b),
    .WriteDataM(wd_b), .ReadDataM(rd_b), .StallMem(stall_b), .AccessErr(err_b)
  );

  typedef struct {
    logic        inst;     // 0 = two wait states, 1 = zero wait states
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        scr;      // scramble inputs during WAIT and DONE
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic drive(input logic inst, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] data);
    if (inst) begin
      req_b = req; we_b = we; addr_b = addr; wd_b = data;
    end else begin
      req_a = req; we_a = we; addr_a = addr; wd_a = data;
    end
  endtask

  // One access starting in an IDLE cycle; returns in its DONE cycle.
  task automatic access(input vec_t v, input int idx);
    int nw;
    nw = v.inst ? 0 : 2;
    @(negedge clk);
    drive(v.inst, 1'b1, v.we, v.addr, v.data);
    #1;
    check($sformatf("v%0d c0 stall", idx), v.inst ? stall_b : stall_a, 32'd1);
    check($sformatf("v%0d c0 err clear", idx), v.inst ? err_b : err_a, 32'd0);
    for (int i = 0; i < nw; i++) begin
      @(negedge clk);
      if (v.scr) drive(v.inst, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       $urandom, $urandom);
      else drive(v.inst, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      check($sformatf("v%0d wait%0d stall", idx, i), v.inst ? stall_b : stall_a, 32'd1);
    end
    @(negedge clk);
    if (v.scr) drive(v.inst, 1'b1, 1'b1, v.addr, 32'h0);
    else drive(v.inst, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check($sformatf("v%0d done stall", idx), v.inst ? stall_b : stall_a, 32'd0);
    check($sformatf("v%0d done rdata", idx), v.inst ? rd_b : rd_a, v.exp_rd);
    check($sformatf("v%0d done err", idx), v.inst ? err_b : err_a, {31'd0, v.exp_err});
  endtask

  initial begin
    //              inst  we    addr           data           exp_rd         err   scr
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0013, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_00FC, 32'hA5A5_0001, 32'hDEAD_BEEF, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0000_00FC, 32'h0,         32'hA5A5_0001, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0020, 32'h1111_2222, 32'hA5A5_0001, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'h1111_2222, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h8000_0010, 32'h5555_5555, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0000_0030, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h0000_0010, 32'h0BAD_F00D, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h0BAD_F00D, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0011, 32'h0,         32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h0000_00FC, 32'h0000_0077, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_00FC, 32'h0,         32'h0000_0077, 1'b0, 1'b0});

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst stall_a", stall_a, 32'd0);
    check("rst rdata_a", rd_a, 32'd0);
    check("rst err_a", err_a, 32'd0);
    check("rst stall_b", stall_b, 32'd0);
    check("rst rdata_b", rd_b, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Vector table; consecutive accesses are back-to-back (request in the IDLE after DONE)
    for (int i = 0; i < vecs.size(); i++) access(vecs[i], i);

    // Reset during WAIT discards a pending store
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    #1;
    check("mid c0 stall", stall_a, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("mid wait stall", stall_a, 32'd1);
    reset = 1'b0;
    #1;
    check("mid rst stall", stall_a, 32'd0);
    check("mid rst rdata", rd_a, 32'd0);
    check("mid rst err", err_a, 32'd0);
    check("mid rst rdata_b", rd_b, 32'd0);
    @(negedge clk);
    #1;
    check("mid held stall", stall_a, 32'd0);
    reset = 1'b1;
    access('{1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h1111_2222, 1'b0, 1'b0}, 100);
    access('{1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0}, 101);

    // IDLE after DONE with no request: stall low, error cleared, data held
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("idle stall_b", stall_b, 32'd0);
    check("idle hold rdata_b", rd_b, 32'h0BAD_F00D);
    check("idle hold rdata_a", rd_a, 32'h1111_2222);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
